// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: accepts one load/store per handshake and answers LATENCY cycles later
// with a single-cycle ack carrying read data or a fault flag. Define DMEM_BYTE_STROBE_EN to add the be_i byte strobes.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
`ifdef DMEM_BYTE_STROBE_EN
    input  logic [3:0]  be_i,
`endif
    output logic        ready_o,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("dmem_responder: LATENCY must lie within 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [3:0]       cnt_reg;
    logic             we_reg;
    logic             fault_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [31:0]      wdata_reg;
    logic [31:0]      rdata_reg;
    logic [31:0]      mem [DEPTH];

    logic             is_idle;
    logic             accept;
    logic             fault_in;
    logic [IDX_W-1:0] idx_in;
    logic             enter_resp;
    logic             mem_we;
    logic             cur_we;
    logic             cur_fault;
    logic [IDX_W-1:0] cur_idx;
    logic [31:0]      cur_wdata;
    logic [3:0]       cur_be;
    logic [3:0]       byte_we;

    assign is_idle  = (state_reg == IDLE);
    assign accept   = is_idle & req_i & ~rst_i;
    assign fault_in = (addr_i[1:0] != 2'b00) || (addr_i[31:2] >= 30'(DEPTH));
    assign idx_in   = addr_i[IDX_W+1:2];

    // With LATENCY==1 the RESP entry coincides with accept, so the live inputs stand in for the capture registers.
    assign cur_we    = is_idle ? we_i     : we_reg;
    assign cur_fault = is_idle ? fault_in : fault_reg;
    assign cur_idx   = is_idle ? idx_in   : idx_reg;
    assign cur_wdata = is_idle ? wdata_i  : wdata_reg;

`ifdef DMEM_BYTE_STROBE_EN
    logic [3:0] be_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            be_reg <= 4'b0000;
        end else if (accept) begin
            be_reg <= be_i;
        end
    end

    assign cur_be = is_idle ? be_i : be_reg;
`else
    assign cur_be = 4'b1111;
`endif

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req_i) begin
                    state_next = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_reg <= 4'd1) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ready_o = 1'b0;
        ack_o   = 1'b0;
        err_o   = 1'b0;
        case (state_reg)
            IDLE: ready_o = 1'b1;
            RESP: begin
                ack_o = 1'b1;
                err_o = fault_reg;
            end
            default: ;
        endcase
    end

    assign rdata_o = rdata_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_reg   <= 4'd0;
            we_reg    <= 1'b0;
            fault_reg <= 1'b0;
            idx_reg   <= '0;
            wdata_reg <= 32'd0;
        end else if (accept) begin
            cnt_reg   <= 4'(LATENCY - 1);
            we_reg    <= we_i;
            fault_reg <= fault_in;
            idx_reg   <= idx_in;
            wdata_reg <= wdata_i;
        end else if (state_reg == WAIT && cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
        end
    end

    // Both the memory write and the load read happen on the edge that enters RESP; reset suppresses both.
    assign enter_resp = ~rst_i & (state_next == RESP);
    assign mem_we     = enter_resp & cur_we & ~cur_fault;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte_we
            assign byte_we[gi] = mem_we & cur_be[gi];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (byte_we[b]) begin
                mem[cur_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_reg <= 32'd0;
        end else if (enter_resp) begin
            if (cur_fault) begin
                rdata_reg <= 32'd0;
            end else if (!cur_we) begin
                rdata_reg <= mem[cur_idx];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized traffic against a word-array model.
// Define DMEM_BYTE_STROBE_EN to also exercise the byte-strobe variant.
module tb_dmem_responder;
    localparam int DEPTH = 256;
    localparam int LAT   = 2;
`ifdef DMEM_BYTE_STROBE_EN
    localparam bit STROBE_EN = 1'b1;
`else
    localparam bit STROBE_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
`ifdef DMEM_BYTE_STROBE_EN
    logic [3:0]  be_i;
`endif
    logic        ready_o;
    logic        ack_o;
    logic [31:0] rdata_o;
    logic        err_o;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: plain word array plus the last value the read-data port should show.
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] ref_rdata;

    always #5 clk_i = ~clk_i;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (req_i),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
`ifdef DMEM_BYTE_STROBE_EN
        .be_i    (be_i),
`endif
        .ready_o (ready_o),
        .ack_o   (ack_o),
        .rdata_o (rdata_o),
        .err_o   (err_o)
    );

    task automatic model_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, output logic exp_err, output logic [31:0] exp_rdata);
        logic [3:0] eff_be;
        int idx;
        eff_be = STROBE_EN ? be : 4'hF;
        if (addr % 4 != 0 || (addr / 4) >= DEPTH) begin
            exp_err   = 1'b1;
            ref_rdata = 32'd0;
        end else begin
            exp_err = 1'b0;
            idx = int'(addr / 4);
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (eff_be[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
                end
            end else begin
                ref_rdata = ref_mem[idx];
            end
        end
        exp_rdata = ref_rdata;
    endtask

    // Drives one request, waits for its accept and ack; lat = cycles from accept to ack (-1 on timeout).
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                         output logic err, output logic [31:0] rdata, output int lat,
                         output logic rdy_at_ack, output logic rdy_after);
        int n;
        @(negedge clk_i);
        req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata;
`ifdef DMEM_BYTE_STROBE_EN
        be_i = be;
`endif
        n = 0;
        while (!ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        @(posedge clk_i);
        #1 req_i = 1'b0;
        lat = -1; err = 1'bx; rdata = 'x; rdy_at_ack = 1'bx;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk_i);
            if (ack_o) begin
                lat = i; err = err_o; rdata = rdata_o; rdy_at_ack = ready_o;
                break;
            end
        end
        @(negedge clk_i);
        rdy_after = ready_o;
        $display("txn we=%0b addr=%h wdata=%h be=%b -> lat=%0d err=%0b rdata=%h", we, addr, wdata, be, lat, err, rdata);
    endtask

    task automatic test_reset();
        rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = 32'd0; wdata_i = 32'd0;
`ifdef DMEM_BYTE_STROBE_EN
        be_i = 4'h0;
`endif
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        ref_rdata = 32'd0;
        @(negedge clk_i);
        compared++; if (ready_o !== 1'b1) begin mismatched++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
        compared++; if (ack_o !== 1'b0) begin mismatched++; $display("FAIL reset_ack got=%b exp=0", ack_o); end
        compared++; if (err_o !== 1'b0) begin mismatched++; $display("FAIL reset_err got=%b exp=0", err_o); end
        compared++; if (rdata_o !== 32'd0) begin mismatched++; $display("FAIL reset_rdata got=%h exp=0", rdata_o); end
    endtask

    task automatic test_store_load();
        logic e, ee, ra, rn;
        logic [31:0] r, er;
        int lat;
        model_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, ee, er);
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, e, r, lat, ra, rn);
        compared++; if (lat !== LAT) begin mismatched++; $display("FAIL st_lat got=%0d exp=%0d", lat, LAT); end
        compared++; if (ra !== 1'b0) begin mismatched++; $display("FAIL st_ready_at_ack got=%b exp=0", ra); end
        compared++; if (rn !== 1'b1) begin mismatched++; $display("FAIL st_ready_after got=%b exp=1", rn); end
        compared++; if (e !== ee) begin mismatched++; $display("FAIL st_err got=%b exp=%b", e, ee); end
        compared++; if (r !== er) begin mismatched++; $display("FAIL st_rdata_held got=%h exp=%h", r, er); end
        model_req(1'b0, 32'h10, 32'h0, 4'hF, ee, er);
        issue(1'b0, 32'h10, 32'h0, 4'hF, e, r, lat, ra, rn);
        compared++; if (lat !== LAT) begin mismatched++; $display("FAIL ld_lat got=%0d exp=%0d", lat, LAT); end
        compared++; if (e !== 1'b0) begin mismatched++; $display("FAIL ld_err got=%b exp=0", e); end
        compared++; if (r !== 32'hDEADBEEF) begin mismatched++; $display("FAIL ld_rdata got=%h exp=deadbeef", r); end
    endtask

    task automatic test_faults();
        logic e, ee, ra, rn;
        logic [31:0] r, er;
        int lat;
        model_req(1'b1, 32'h0, 32'h0BADF00D, 4'hF, ee, er);
        issue(1'b1, 32'h0, 32'h0BADF00D, 4'hF, e, r, lat, ra, rn);
        compared++; if (e !== ee) begin mismatched++; $display("FAIL flt_init_err got=%b exp=%b", e, ee); end
        model_req(1'b0, 32'h13, 32'h0, 4'hF, ee, er);
        issue(1'b0, 32'h13, 32'h0, 4'hF, e, r, lat, ra, rn);
        compared++; if (lat !== LAT) begin mismatched++; $display("FAIL flt_mis_lat got=%0d exp=%0d", lat, LAT); end
        compared++; if (e !== 1'b1) begin mismatched++; $display("FAIL flt_mis_err got=%b exp=1", e); end
        compared++; if (r !== 32'd0) begin mismatched++; $display("FAIL flt_mis_rdata got=%h exp=0", r); end
        model_req(1'b1, 32'h400, 32'h12345678, 4'hF, ee, er);
        issue(1'b1, 32'h400, 32'h12345678, 4'hF, e, r, lat, ra, rn);
        compared++; if (lat !== LAT) begin mismatched++; $display("FAIL flt_oor_lat got=%0d exp=%0d", lat, LAT); end
        compared++; if (e !== 1'b1) begin mismatched++; $display("FAIL flt_oor_err got=%b exp=1", e); end
        model_req(1'b0, 32'h0, 32'h0, 4'hF, ee, er);
        issue(1'b0, 32'h0, 32'h0, 4'hF, e, r, lat, ra, rn);
        compared++; if (r !== 32'h0BADF00D) begin mismatched++; $display("FAIL flt_old_rdata got=%h exp=0badf00d", r); end
        compared++; if (e !== 1'b0) begin mismatched++; $display("FAIL flt_old_err got=%b exp=0", e); end
    endtask

    task automatic test_back_to_back();
        logic e, ee1, ee2, ra, rn, prev_ack;
        logic [31:0] r, er1, er2, r1, r2;
        int lat, first, second, acc2, consec, n;
        model_req(1'b1, 32'h40, 32'hA5A50001, 4'hF, ee1, er1);
        issue(1'b1, 32'h40, 32'hA5A50001, 4'hF, e, r, lat, ra, rn);
        model_req(1'b1, 32'h44, 32'h5A5A0002, 4'hF, ee1, er1);
        issue(1'b1, 32'h44, 32'h5A5A0002, 4'hF, e, r, lat, ra, rn);
        model_req(1'b0, 32'h40, 32'h0, 4'hF, ee1, er1);
        model_req(1'b0, 32'h44, 32'h0, 4'hF, ee2, er2);
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h40;
        n = 0;
        while (!ready_o && n < 50) begin @(negedge clk_i); n++; end
        @(posedge clk_i);
        #1 addr_i = 32'h44;
        first = -1; second = -1; acc2 = -1; consec = 0; prev_ack = 1'b0; r1 = 'x; r2 = 'x;
        for (int t = 1; t <= 2*LAT + 4; t++) begin
            @(negedge clk_i);
            if (acc2 >= 0 && t == acc2 + 1) req_i = 1'b0;
            if (ack_o && prev_ack) consec++;
            if (ack_o && first < 0) begin first = t; r1 = rdata_o; end
            else if (ack_o && second < 0) begin second = t; r2 = rdata_o; end
            if (ready_o && req_i && first >= 0 && acc2 < 0) acc2 = t;
            prev_ack = ack_o;
        end
        req_i = 1'b0;
        $display("txn back-to-back loads 40/44 -> acks at %0d,%0d accept2 at %0d", first, second, acc2);
        compared++; if (first !== LAT) begin mismatched++; $display("FAIL b2b_first_ack got=%0d exp=%0d", first, LAT); end
        compared++; if (acc2 !== LAT + 1) begin mismatched++; $display("FAIL b2b_accept2 got=%0d exp=%0d", acc2, LAT + 1); end
        compared++; if (second !== 2*LAT + 1) begin mismatched++; $display("FAIL b2b_second_ack got=%0d exp=%0d", second, 2*LAT + 1); end
        compared++; if (consec !== 0) begin mismatched++; $display("FAIL b2b_consec_ack got=%0d exp=0", consec); end
        compared++; if (r1 !== er1) begin mismatched++; $display("FAIL b2b_rdata1 got=%h exp=%h", r1, er1); end
        compared++; if (r2 !== er2) begin mismatched++; $display("FAIL b2b_rdata2 got=%h exp=%h", r2, er2); end
    endtask

    task automatic test_reset_midop();
        logic e, ee, ra, rn;
        logic [31:0] r, er;
        int lat, acks, n;
        model_req(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, ee, er);
        issue(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, e, r, lat, ra, rn);
        model_req(1'b0, 32'h20, 32'h0, 4'hF, ee, er);
        issue(1'b0, 32'h20, 32'h0, 4'hF, e, r, lat, ra, rn);
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'h20; wdata_i = 32'h55;
        n = 0;
        while (!ready_o && n < 50) begin @(negedge clk_i); n++; end
        @(posedge clk_i);
        #1 req_i = 1'b0; rst_i = 1'b1;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        ref_rdata = 32'd0;
        @(negedge clk_i);
        $display("txn store 55 to 20 abandoned by reset");
        compared++; if (ready_o !== 1'b1) begin mismatched++; $display("FAIL midrst_ready got=%b exp=1", ready_o); end
        compared++; if (rdata_o !== 32'd0) begin mismatched++; $display("FAIL midrst_rdata got=%h exp=0", rdata_o); end
        acks = ack_o ? 1 : 0;
        repeat (4) begin @(negedge clk_i); if (ack_o) acks++; end
        compared++; if (acks !== 0) begin mismatched++; $display("FAIL midrst_no_ack got=%0d exp=0", acks); end
        model_req(1'b0, 32'h20, 32'h0, 4'hF, ee, er);
        issue(1'b0, 32'h20, 32'h0, 4'hF, e, r, lat, ra, rn);
        compared++; if (r !== 32'hCAFEF00D) begin mismatched++; $display("FAIL midrst_old_word got=%h exp=cafef00d", r); end
    endtask

    task automatic test_random();
        logic e, ee, ra, rn, we;
        logic [31:0] r, er, addr, wdata;
        logic [3:0] be;
        int lat, sel;
        for (int i = 0; i < 16; i++) begin
            wdata = $urandom;
            model_req(1'b1, 32'(i * 4), wdata, 4'hF, ee, er);
            issue(1'b1, 32'(i * 4), wdata, 4'hF, e, r, lat, ra, rn);
            compared++; if (e !== ee) begin mismatched++; $display("FAIL init_err[%0d] got=%b exp=%b", i, e, ee); end
        end
        for (int i = 0; i < 60; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0) addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
            else if (sel == 1) addr = ($urandom | 32'h8000_0000) & 32'hFFFF_FFFC;
            else addr = 32'($urandom_range(0, 15) * 4);
            we = 1'($urandom_range(0, 1));
            wdata = $urandom;
            be = STROBE_EN ? 4'($urandom_range(0, 15)) : 4'hF;
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
            model_req(we, addr, wdata, be, ee, er);
            issue(we, addr, wdata, be, e, r, lat, ra, rn);
            compared++; if (lat !== LAT) begin mismatched++; $display("FAIL rnd_lat[%0d] got=%0d exp=%0d", i, lat, LAT); end
            compared++; if (e !== ee) begin mismatched++; $display("FAIL rnd_err[%0d] got=%b exp=%b", i, e, ee); end
            compared++; if (r !== er) begin mismatched++; $display("FAIL rnd_rdata[%0d] got=%h exp=%h", i, r, er); end
        end
    endtask

`ifdef DMEM_BYTE_STROBE_EN
    task automatic test_byte_strobe();
        logic e, ee, ra, rn;
        logic [31:0] r, er;
        int lat;
        model_req(1'b1, 32'h20, 32'h11223344, 4'hF, ee, er);
        issue(1'b1, 32'h20, 32'h11223344, 4'hF, e, r, lat, ra, rn);
        model_req(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, ee, er);
        issue(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, e, r, lat, ra, rn);
        model_req(1'b0, 32'h20, 32'h0, 4'h0, ee, er);
        issue(1'b0, 32'h20, 32'h0, 4'h0, e, r, lat, ra, rn);
        compared++; if (r !== 32'h11BB33DD) begin mismatched++; $display("FAIL be_merge got=%h exp=11bb33dd", r); end
        model_req(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, ee, er);
        issue(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, e, r, lat, ra, rn);
        compared++; if (e !== 1'b0) begin mismatched++; $display("FAIL be_zero_err got=%b exp=0", e); end
        compared++; if (lat !== LAT) begin mismatched++; $display("FAIL be_zero_lat got=%0d exp=%0d", lat, LAT); end
        model_req(1'b0, 32'h20, 32'h0, 4'h0, ee, er);
        issue(1'b0, 32'h20, 32'h0, 4'h0, e, r, lat, ra, rn);
        compared++; if (r !== 32'h11BB33DD) begin mismatched++; $display("FAIL be_zero_word got=%h exp=11bb33dd", r); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired before the bench completed");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_load();
        test_faults();
        test_back_to_back();
        test_reset_midop();
        test_random();
`ifdef DMEM_BYTE_STROBE_EN
        test_byte_strobe();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
